// File: rtl/psc_trigger_tx_multi.sv
// -----------------------------------------------------------------------------
// psc_trigger_tx_multi
//
// Multi-channel power-supply trigger transmitter. Every channel continuously
// sends 4-byte CRC-protected frames on its own serial line; a frame is marked
// "trigger" when that channel's EVR trigger edge arrived before the frame
// boundary. Bit and frame timing come from clock enables on the single clk.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low; clears all state
//   evr_trigger  [N_CH] asynchronous trigger inputs
//   psc_output   [N_CH] serial frame lines, idle high
//   frame_start  one-clk pulse when bit 0 of a frame starts on all lines
//   bit_strobe   one-clk pulse at the start of every bit time
//   trig_sent    [N_CH] one-clk pulse with frame_start for trigger frames
//   overrun      [N_CH] sticky: a trigger was lost while one was pending
//
// Frame (transmitted byte order, each byte as start 0, data LSB first, stop 1):
//   HEADER, {seq, type}, channel index, CRC-8 (poly 0x07, init 0) of bytes 0..2
//   followed by GAP_BITS idle-high bit times.
// -----------------------------------------------------------------------------
module psc_trigger_tx_multi #(
  parameter int          N_CH     = 4,
  parameter int          BIT_DIV  = 5,
  parameter int          GAP_BITS = 10,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter bit          TRIG_INV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] evr_trigger,
  output logic [N_CH-1:0] psc_output,
  output logic            frame_start,
  output logic            bit_strobe,
  output logic [N_CH-1:0] trig_sent,
  output logic [N_CH-1:0] overrun
);

  localparam int FRAME_BITS = 40;
  localparam int TOTAL_BITS = FRAME_BITS + GAP_BITS;
  localparam int DIV_W      = $clog2(BIT_DIV);
  localparam int IDX_W      = $clog2(TOTAL_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_GAP  = IDX_W'(FRAME_BITS);
  // Raw synchroniser reset value is the inactive input level, so leaving
  // reset never manufactures a trigger edge.
  localparam logic [N_CH-1:0] IDLE_RAW  = {N_CH{TRIG_INV}};

  // One byte of CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc8(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int j = 0; j < 8; j++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Whole frame as a 40-bit vector; bit k is the k-th bit put on the line.
  function automatic logic [39:0] build_frame(input logic [3:0] seq, input logic is_trig,
                                              input logic [7:0] ch);
    logic [7:0]  bytes [4];
    logic [39:0] bits;
    bytes[0] = HEADER;
    bytes[1] = {seq, 3'b000, is_trig};
    bytes[2] = ch;
    bytes[3] = crc8(crc8(crc8(8'h00, bytes[0]), bytes[1]), bytes[2]);
    for (int k = 0; k < 4; k++) begin
      bits[10*k +: 10] = {1'b1, bytes[k], 1'b0};
    end
    return bits;
  endfunction

  // Shared timing: active_q is low only until the first edge after reset.
  logic                   active_q, active_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   fs_q, fs_d;
  logic                   strobe_q, strobe_d;

  // Per-channel trigger path and transmit state.
  logic [N_CH-1:0]        sync1_q, sync1_d;
  logic [N_CH-1:0]        sync2_q, sync2_d;
  logic [N_CH-1:0]        level_q, level_d;
  logic [N_CH-1:0]        edge_q, edge_d;
  logic [N_CH-1:0]        pending_q, pending_d;
  logic [N_CH-1:0]        overrun_q, overrun_d;
  logic [N_CH-1:0]        trig_q, trig_d;
  logic [N_CH-1:0]        psc_q, psc_d;
  logic [N_CH-1:0][3:0]   seq_q, seq_d;
  logic [N_CH-1:0][39:0]  frame_q, frame_d;

  always_comb begin
    // NOTE: every _d signal gets a default before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    sync1_d   = evr_trigger;
    sync2_d   = sync1_q;
    level_d   = sync2_q ^ IDLE_RAW;
    edge_d    = level_d & ~level_q;
    active_d  = 1'b1;
    div_d     = div_q;
    idx_d     = idx_q;
    fs_d      = 1'b0;
    strobe_d  = 1'b0;
    pending_d = pending_q;
    overrun_d = overrun_q;
    seq_d     = seq_q;
    frame_d   = frame_q;
    trig_d    = '0;
    psc_d     = '1;

    if (!active_q) begin
      // First edge out of reset starts frame 0 at bit 0.
      div_d    = '0;
      idx_d    = '0;
      fs_d     = 1'b1;
      strobe_d = 1'b1;
    end else if (div_q == DIV_LAST) begin
      div_d    = '0;
      strobe_d = 1'b1;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        fs_d  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end

    for (int i = 0; i < N_CH; i++) begin
      if (fs_d) begin
        // Latch frame type from pending; an edge arriving in this same cycle
        // re-arms pending for the following frame instead of being lost.
        frame_d[i]   = build_frame(seq_q[i], pending_q[i], 8'(i));
        trig_d[i]    = pending_q[i];
        pending_d[i] = edge_q[i];
        if (pending_q[i]) begin
          seq_d[i] = seq_q[i] + 4'd1;
        end
      end else if (edge_q[i]) begin
        if (pending_q[i]) begin
          overrun_d[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
      end
      psc_d[i] = (idx_d < IDX_GAP) ? frame_d[i][idx_d[5:0]] : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    if (!reset) begin
      active_q  <= 1'b0;
      div_q     <= '0;
      idx_q     <= '0;
      fs_q      <= 1'b0;
      strobe_q  <= 1'b0;
      sync1_q   <= IDLE_RAW;
      sync2_q   <= IDLE_RAW;
      level_q   <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      trig_q    <= '0;
      psc_q     <= '1;
      seq_q     <= '0;
      // NOTE: the frame store is reset with everything else; it is only
      // N_CH x 40 flops and keeps the post-reset state fully defined.
      frame_q   <= '0;
    end else begin
      active_q  <= active_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      fs_q      <= fs_d;
      strobe_q  <= strobe_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      trig_q    <= trig_d;
      psc_q     <= psc_d;
      seq_q     <= seq_d;
      frame_q   <= frame_d;
    end
  end

  assign psc_output  = psc_q;
  assign frame_start = fs_q;
  assign bit_strobe  = strobe_q;
  assign trig_sent   = trig_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_psc_trigger_tx_multi.sv
// -----------------------------------------------------------------------------
// tb_psc_trigger_tx_multi
//
// Directed bench for psc_trigger_tx_multi. dut_a uses the default parameters
// (4 channels, BIT_DIV=5, GAP_BITS=10, active-low triggers); dut_b uses
// 2 channels, BIT_DIV=2, GAP_BITS=1, active-high triggers. A small receiver
// captures whole frames and checks framing, header, channel index and CRC of
// every channel; the test body checks the seq/type byte, trig_sent and
// overrun against hand-derived values.
// -----------------------------------------------------------------------------
module tb_psc_trigger_tx_multi;

  localparam int N_A = 4;
  localparam int N_B = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N_A-1:0] evr_a = '1;
  logic [N_B-1:0] evr_b = '0;
  logic [N_A-1:0] psc_a, trig_a, ovr_a;
  logic           fs_a, strobe_a;
  logic [N_B-1:0] psc_b, trig_b, ovr_b;
  logic           fs_b, strobe_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rel_cyc  = 0;
  int fs_cyc   = 0;

  logic [N_A-1:0][39:0] rx_bits;
  logic [N_A-1:0]       rx_trig;

  psc_trigger_tx_multi dut_a (
    .clk         (clk),
    .reset       (reset),
    .evr_trigger (evr_a),
    .psc_output  (psc_a),
    .frame_start (fs_a),
    .bit_strobe  (strobe_a),
    .trig_sent   (trig_a),
    .overrun     (ovr_a)
  );

  psc_trigger_tx_multi #(
    .N_CH     (N_B),
    .BIT_DIV  (2),
    .GAP_BITS (1),
    .HEADER   (8'hA5),
    .TRIG_INV (1'b0)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .evr_trigger (evr_b),
    .psc_output  (psc_b),
    .frame_start (fs_b),
    .bit_strobe  (strobe_b),
    .trig_sent   (trig_b),
    .overrun     (ovr_b)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x07, init 0), bit-serial over a 3-byte message.
  function automatic logic [7:0] crc_model(input logic [23:0] msg);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 23; i >= 0; i--) begin
      fb  = crc[7] ^ msg[i];
      crc = {crc[6:0], 1'b0};
      if (fb) crc = crc ^ 8'h07;
    end
    return crc;
  endfunction

  function automatic logic [7:0] rx_byte(input int ch, input int k);
    return rx_bits[ch][10*k+1 +: 8];
  endfunction

  function automatic logic framing_ok(input int ch);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (rx_bits[ch][10*k] !== 1'b0 || rx_bits[ch][10*k+9] !== 1'b1) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_fs(input bit inst, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if ((inst ? fs_b : fs_a) === 1'b1) ok = 1'b1;
    end
    fs_cyc = cyc;
  endtask

  // Waits for the next frame_start, samples all lines on the first clk of
  // each of the 40 frame bits, then checks the fixed frame fields. Returns on
  // the first clk of bit 39.
  task automatic rx_frame(input bit inst);
    bit             ok;
    int             div;
    int             nch;
    logic [N_A-1:0] line;
    div = inst ? 2 : 5;
    nch = inst ? N_B : N_A;
    wait_fs(inst, ok);
    check("fs_seen", 64'(ok), 64'h1);
    rx_trig = inst ? {{(N_A-N_B){1'b0}}, trig_b} : trig_a;
    for (int b = 0; b < 40; b++) begin
      line = inst ? {{(N_A-N_B){1'b1}}, psc_b} : psc_a;
      for (int ch = 0; ch < N_A; ch++) rx_bits[ch][b] = line[ch];
      if (b != 39) repeat (div) @(negedge clk);
    end
    for (int ch = 0; ch < nch; ch++) begin
      check($sformatf("framing_ch%0d", ch), 64'(framing_ok(ch)), 64'h1);
      check($sformatf("header_ch%0d", ch), 64'(rx_byte(ch, 0)), 64'hA5);
      check($sformatf("chan_idx_ch%0d", ch), 64'(rx_byte(ch, 2)), 64'(ch));
      check($sformatf("crc_ch%0d", ch), 64'(rx_byte(ch, 3)),
            64'(crc_model({rx_byte(ch, 0), rx_byte(ch, 1), rx_byte(ch, 2)})));
    end
  endtask

  task automatic pulse_a(input int ch, input int low_cycles);
    evr_a[ch] = 1'b0;
    repeat (low_cycles) @(negedge clk);
    evr_a[ch] = 1'b1;
  endtask

  task automatic restart(input int hold);
    @(negedge clk);
    reset = 1'b0;
    repeat (hold) @(negedge clk);
    reset   = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    logic [9:0] pat;
    logic       hi;
    int         t0;
    bit         ok;

    // ---- reset state ----
    repeat (4) @(negedge clk);
    check("rst_psc_a", 64'(psc_a), 64'hF);
    check("rst_fs_a", 64'(fs_a), 64'h0);
    check("rst_strobe_a", 64'(strobe_a), 64'h0);
    check("rst_trig_a", 64'(trig_a), 64'h0);
    check("rst_ovr_a", 64'(ovr_a), 64'h0);
    check("rst_psc_b", 64'(psc_b), 64'h3);
    reset   = 1'b1;
    rel_cyc = cyc;

    // ---- idle frames, defaults ----
    rx_frame(1'b0);
    check("first_fs_latency", 64'(fs_cyc - rel_cyc), 64'd1);
    check("idle_trig", 64'(rx_trig), 64'h0);
    check("idle_b1_ch0", 64'(rx_byte(0, 1)), 64'h00);
    check("idle_crc_ch0", 64'(rx_byte(0, 3)), 64'h88);
    check("idle_b3_bits_ch0", 64'(rx_bits[0][39:30]), 64'b1100010000);
    pat = '0;
    hi  = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      pat[j] = strobe_a;
      hi     = hi & (&psc_a);
    end
    check("strobe_pattern", 64'(pat), 64'b1000010000);
    check("gap_high", 64'(hi), 64'h1);
    t0 = fs_cyc;
    rx_frame(1'b0);
    check("frame_period", 64'(fs_cyc - t0), 64'd250);

    // ---- single trigger on ch0 at clk 20 after release ----
    restart(2);
    repeat (20) @(negedge clk);
    pulse_a(0, 4);
    rx_frame(1'b0);
    check("trig1_sent", 64'(rx_trig), 64'h1);
    check("trig1_b1_ch0", 64'(rx_byte(0, 1)), 64'h01);
    check("trig1_crc_ch0", 64'(rx_byte(0, 3)), 64'h9D);
    check("trig1_b1_ch1", 64'(rx_byte(1, 1)), 64'h00);
    check("trig1_b1_ch2", 64'(rx_byte(2, 1)), 64'h00);
    check("trig1_b1_ch3", 64'(rx_byte(3, 1)), 64'h00);
    rx_frame(1'b0);
    check("after1_sent", 64'(rx_trig), 64'h0);
    check("after1_b1_ch0", 64'(rx_byte(0, 1)), 64'h10);

    // ---- two edges on ch2 within one frame -> overrun ----
    pulse_a(2, 3);
    repeat (3) @(negedge clk);
    pulse_a(2, 3);
    rx_frame(1'b0);
    check("dbl_sent", 64'(rx_trig), 64'h4);
    check("dbl_b1_ch2", 64'(rx_byte(2, 1)), 64'h01);
    check("dbl_b1_ch0", 64'(rx_byte(0, 1)), 64'h10);
    check("dbl_overrun", 64'(ovr_a), 64'h4);
    rx_frame(1'b0);
    check("dbl_next_sent", 64'(rx_trig), 64'h0);
    check("dbl_next_b1_ch2", 64'(rx_byte(2, 1)), 64'h10);
    check("dbl_overrun_sticky", 64'(ovr_a), 64'h4);

    // ---- edge one clk before / exactly in the frame_start cycle ----
    // rx_frame returns 55 clk before the next frame_start.
    repeat (50) @(negedge clk);
    evr_a[1] = 1'b0;
    @(negedge clk);
    evr_a[3] = 1'b0;
    rx_frame(1'b0);
    check("bnd_sent", 64'(rx_trig), 64'h2);
    check("bnd_b1_ch1", 64'(rx_byte(1, 1)), 64'h01);
    check("bnd_b1_ch3", 64'(rx_byte(3, 1)), 64'h00);
    evr_a = '1;
    rx_frame(1'b0);
    check("bnd_next_sent", 64'(rx_trig), 64'h8);
    check("bnd_next_b1_ch3", 64'(rx_byte(3, 1)), 64'h01);
    check("bnd_next_b1_ch1", 64'(rx_byte(1, 1)), 64'h10);
    check("bnd_overrun", 64'(ovr_a), 64'h4);

    // ---- 17 triggers on ch1, two frames apart: seq 0..15 then 0 ----
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_overrun", 64'(ovr_a), 64'h0);
    check("rst2_psc", 64'(psc_a), 64'hF);
    reset   = 1'b1;
    rel_cyc = cyc;
    rx_frame(1'b0);
    check("seq_start_b1_ch1", 64'(rx_byte(1, 1)), 64'h00);
    for (int t = 0; t < 17; t++) begin
      repeat (2) @(negedge clk);
      pulse_a(1, 3);
      rx_frame(1'b0);
      check($sformatf("seq_trig_sent_%0d", t), 64'(rx_trig), 64'h2);
      check($sformatf("seq_trig_b1_%0d", t), 64'(rx_byte(1, 1)), 64'({4'(t), 4'h1}));
      rx_frame(1'b0);
      check($sformatf("seq_idle_b1_%0d", t), 64'(rx_byte(1, 1)), 64'({4'(t + 1), 4'h0}));
    end

    // ---- reset at bit 13 of a trigger frame ----
    pulse_a(0, 3);
    wait_fs(1'b0, ok);
    check("abort_fs_seen", 64'(ok), 64'h1);
    check("abort_trig_sent", 64'(trig_a), 64'h1);
    @(negedge clk);
    pulse_a(2, 3);
    repeat (3) @(negedge clk);
    pulse_a(2, 3);
    repeat (56) @(negedge clk);
    check("abort_pre_overrun", 64'(ovr_a), 64'h4);
    check("abort_bit13_lines", 64'(psc_a), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_psc_high", 64'(psc_a), 64'hF);
    check("abort_fs", 64'(fs_a), 64'h0);
    check("abort_strobe", 64'(strobe_a), 64'h0);
    check("abort_trig", 64'(trig_a), 64'h0);
    check("abort_overrun", 64'(ovr_a), 64'h0);
    check("abort_psc_b", 64'(psc_b), 64'h3);
    @(negedge clk);
    reset   = 1'b1;
    rel_cyc = cyc;
    rx_frame(1'b0);
    check("abort_first_latency", 64'(fs_cyc - rel_cyc), 64'd1);
    check("abort_first_sent", 64'(rx_trig), 64'h0);
    check("abort_first_b1_ch0", 64'(rx_byte(0, 1)), 64'h00);
    check("abort_first_b1_ch2", 64'(rx_byte(2, 1)), 64'h00);
    rx_frame(1'b0);
    check("abort_second_sent", 64'(rx_trig), 64'h0);

    // ---- fast configuration: BIT_DIV=2, GAP_BITS=1, active-high ----
    restart(2);
    rx_frame(1'b1);
    check("b_first_latency", 64'(fs_cyc - rel_cyc), 64'd1);
    check("b_first_sent", 64'(rx_trig), 64'h0);
    check("b_first_b1_ch0", 64'(rx_byte(0, 1)), 64'h00);
    pat = '0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      pat[j] = strobe_b;
    end
    check("b_strobe_pattern", 64'(pat), 64'b10);
    t0 = fs_cyc;
    rx_frame(1'b1);
    check("b_frame_period", 64'(fs_cyc - t0), 64'd82);
    // Rising input here yields an edge pulse in the frame_start cycle.
    evr_b[0] = 1'b1;
    rx_frame(1'b1);
    check("b_bnd_sent", 64'(rx_trig), 64'h0);
    check("b_bnd_b1_ch0", 64'(rx_byte(0, 1)), 64'h00);
    rx_frame(1'b1);
    check("b_trig_sent", 64'(rx_trig), 64'h1);
    check("b_trig_b1_ch0", 64'(rx_byte(0, 1)), 64'h01);
    check("b_trig_b1_ch1", 64'(rx_byte(1, 1)), 64'h00);
    check("b_overrun", 64'(ovr_b), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
